// File: rtl/controlador_posicao_alvo.sv
// -----------------------------------------------------------------------------
// controlador_posicao_alvo
//
// Purpose:
//    Target-position controller. Accepts a 3-bit target code while idle and
//    walks a registered 3-bit position one step every STEP_DIV cycles toward
//    it. On arrival it pulses `arrived`, then dwells for DWELL cycles before
//    it accepts the next request. `match` is the 3-bit equality decision
//    between the position and the target, in the same form the code
//    comparator produces.
//
// Parameters:
//    STEP_DIV  clock cycles per position step (>=1)
//    DWELL     cycles spent dwelling after arrival (>=1)
//
// Ports:
//    clk         single clock, rising edge
//    rst_n       synchronous active-low reset
//    req_valid   target request present
//    req_target  requested code 0..7
//    req_ready   block is idle and can accept a request
//    pos         current position code
//    match       pos == target (decoded from registers)
//    mov_up      moving toward a higher code
//    mov_dn      moving toward a lower code
//    arrived     one-cycle registered pulse on arrival
//    busy        state is not IDLE
// -----------------------------------------------------------------------------
module controlador_posicao_alvo #(
   parameter int STEP_DIV = 4,
   parameter int DWELL    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [2:0] req_target,
   output logic       req_ready,
   output logic [2:0] pos,
   output logic       match,
   output logic       mov_up,
   output logic       mov_dn,
   output logic       arrived,
   output logic       busy
);

   localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MOVE  = 2'd1,
      S_DWELL = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [2:0]      r_pos;
   logic [2:0]      r_target;
   logic [SW-1:0]   r_step_cnt;
   logic [DW-1:0]   r_dwell_cnt;
   logic            r_dir;        // 1 = up, 0 = down
   logic            r_arrived;

   logic            w_step_edge;
   logic [2:0]      w_pos_step;
   logic            w_arrive_move;
   logic            w_dwell_done;
   logic [2:0]      w_eq_bits;

   // One saturating step. A legal request never reaches the rails in the
   // wrong direction, but the position must never wrap 7<->0.
   function automatic logic [2:0] step_sat(input logic [2:0] p, input logic up);
      if (up) begin
         return (p == 3'd7) ? p : p + 3'd1;
      end else begin
         return (p == 3'd0) ? p : p - 3'd1;
      end
   endfunction

   assign w_step_edge   = (r_state == S_MOVE) && (r_step_cnt == STEP_LAST);
   assign w_pos_step    = step_sat(r_pos, r_dir);
   assign w_arrive_move = w_step_edge && (w_pos_step == r_target);
   assign w_dwell_done  = (r_state == S_DWELL) && (r_dwell_cnt == DWELL_LAST);

   // Bitwise equality, reduced by AND: same decision the comparator emits.
   assign w_eq_bits = ~(r_pos ^ r_target);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_state_nxt = (req_target == r_pos) ? S_DWELL : S_MOVE;
            end
         end
         S_MOVE: begin
            if (w_arrive_move) begin
               w_state_nxt = S_DWELL;
            end
         end
         S_DWELL: begin
            if (w_dwell_done) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Position, target, counters and arrival pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pos       <= 3'd0;
         r_target    <= 3'd0;
         r_step_cnt  <= '0;
         r_dwell_cnt <= '0;
         r_dir       <= 1'b1;
         r_arrived   <= 1'b0;
      end else begin
         // Pulse only on the transition into DWELL, never while dwelling.
         r_arrived <= (w_state_nxt == S_DWELL) && (r_state != S_DWELL);
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_target    <= req_target;
                  r_step_cnt  <= '0;
                  r_dwell_cnt <= '0;
                  r_dir       <= (req_target > r_pos);
               end
            end
            S_MOVE: begin
               if (w_step_edge) begin
                  r_pos      <= w_pos_step;
                  r_step_cnt <= '0;
                  if (w_arrive_move) begin
                     r_dwell_cnt <= '0;
                  end
               end else begin
                  r_step_cnt <= r_step_cnt + SW'(1);
               end
            end
            S_DWELL: begin
               r_dwell_cnt <= w_dwell_done ? '0 : r_dwell_cnt + DW'(1);
            end
            default: begin
               r_step_cnt <= '0;
            end
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign mov_up    = (r_state == S_MOVE) &&  r_dir;
   assign mov_dn    = (r_state == S_MOVE) && !r_dir;
   assign match     = &w_eq_bits;
   assign pos       = r_pos;
   assign arrived   = r_arrived;

endmodule

// File: tb/tb_controlador_posicao_alvo.sv
module tb_controlador_posicao_alvo;

   localparam int SD = 4;
   localparam int DW = 8;
   localparam int EV_POS = 0;
   localparam int EV_ARR = 1;

   typedef struct {
      int         cyc;
      int         kind;
      logic [2:0] val;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b1;
   logic [2:0] req_target = 3'd5;
   logic       req_ready;
   logic [2:0] pos;
   logic       match;
   logic       mov_up;
   logic       mov_dn;
   logic       arrived;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   ev_t        sb[$];
   logic [2:0] m_pos = 3'd0;
   int         b_start = 1, b_end = 0;
   int         mv_start = 1, mv_end = 0;
   logic       mv_up = 1'b1;
   int         ready_cyc = 0;
   logic [2:0] prev_pos = 3'd0;

   controlador_posicao_alvo #(.STEP_DIV(SD), .DWELL(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_target(req_target),
      .req_ready (req_ready),
      .pos       (pos),
      .match     (match),
      .mov_up    (mov_up),
      .mov_dn    (mov_dn),
      .arrived   (arrived),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: pops expected events as the DUT produces them and
   // checks the busy / direction windows every cycle.
   always @(negedge clk) begin
      ev_t ev;
      logic exp_busy, exp_up, exp_dn, in_mv;
      if (!rst_n) begin
         prev_pos = pos;
      end else begin
         if (pos !== prev_pos) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL pos_unexpected cyc=%0d pos=%0d required=no change", cyc, pos);
            end else begin
               ev = sb.pop_front();
               if (ev.kind !== EV_POS || ev.cyc !== cyc || ev.val !== pos) begin
                  n_err++;
                  $display("FAIL pos_event got cyc=%0d pos=%0d required kind=%0d cyc=%0d pos=%0d",
                           cyc, pos, ev.kind, ev.cyc, ev.val);
               end
            end
         end
         if (arrived === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL arrived_unexpected cyc=%0d pos=%0d", cyc, pos);
            end else begin
               ev = sb.pop_front();
               if (ev.kind !== EV_ARR || ev.cyc !== cyc || ev.val !== pos || match !== 1'b1) begin
                  n_err++;
                  $display("FAIL arrived_event got cyc=%0d pos=%0d match=%0b required kind=%0d cyc=%0d pos=%0d match=1",
                           cyc, pos, match, ev.kind, ev.cyc, ev.val);
               end
            end
         end
         exp_busy = (cyc >= b_start) && (cyc <= b_end);
         n_vec++;
         if (busy !== exp_busy || req_ready !== !exp_busy) begin
            n_err++;
            $display("FAIL busy_window cyc=%0d busy=%0b ready=%0b required busy=%0b ready=%0b",
                     cyc, busy, req_ready, exp_busy, !exp_busy);
         end
         in_mv  = (cyc >= mv_start) && (cyc <= mv_end);
         exp_up = in_mv && mv_up;
         exp_dn = in_mv && !mv_up;
         n_vec++;
         if (mov_up !== exp_up || mov_dn !== exp_dn) begin
            n_err++;
            $display("FAIL move_dir cyc=%0d up=%0b dn=%0b required up=%0b dn=%0b",
                     cyc, mov_up, mov_dn, exp_up, exp_dn);
         end
         prev_pos = pos;
      end
   end

   // Push the expected trajectory of a request accepted at edge k.
   task automatic push_expect(input logic [2:0] t, input int k);
      int  d;
      logic up;
      up = (t > m_pos);
      d  = up ? int'(t) - int'(m_pos) : int'(m_pos) - int'(t);
      for (int i = 1; i <= d; i++) begin
         sb.push_back('{k + SD * i, EV_POS, up ? 3'(int'(m_pos) + i) : 3'(int'(m_pos) - i)});
      end
      sb.push_back('{k + SD * d, EV_ARR, t});
      mv_start  = k;
      mv_end    = k + SD * d - 1;
      mv_up     = up;
      b_start   = k;
      b_end     = k + SD * d + DW - 1;
      ready_cyc = k + SD * d + DW;
      m_pos     = t;
   endtask

   // Called #1 after an edge with the DUT idle; accepted at the next edge.
   task automatic request(input logic [2:0] t);
      req_valid  = 1'b1;
      req_target = t;
      @(posedge clk); #1;
      req_valid = 1'b0;
      push_expect(t, cyc);
   endtask

   task automatic wait_until(input int c);
      int g = 0;
      while (cyc < c && g < 1000) begin
         @(posedge clk); #1;
         g++;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = 1'b0;
      n_vec++;
      if (pos !== 3'd0 || match !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state pos=%0d match=%0b ready=%0b busy=%0b required 0 1 1 0",
                  pos, match, req_ready, busy);
      end
      n_vec++;
      if (arrived !== 1'b0 || mov_up !== 1'b0 || mov_dn !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs arrived=%0b up=%0b dn=%0b required 0 0 0", arrived, mov_up, mov_dn);
      end
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b0 || pos !== 3'd0) begin
         n_err++;
         $display("FAIL reset_no_accept busy=%0b pos=%0d required busy=0 pos=0", busy, pos);
      end
   endtask

   task automatic test_up_move;
      request(3'd3);
      n_vec++;
      if (busy !== 1'b1 || req_ready !== 1'b0 || mov_up !== 1'b1 || match !== 1'b0) begin
         n_err++;
         $display("FAIL up_start busy=%0b ready=%0b up=%0b match=%0b required 1 0 1 0",
                  busy, req_ready, mov_up, match);
      end
      wait_until(ready_cyc);
      n_vec++;
      if (sb.size() != 0 || pos !== 3'd3 || match !== 1'b1 || req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL up_end pending=%0d pos=%0d match=%0b ready=%0b required 0 3 1 1",
                  sb.size(), pos, match, req_ready);
      end
   endtask

   task automatic test_down_move;
      request(3'd0);
      n_vec++;
      if (mov_dn !== 1'b1 || mov_up !== 1'b0) begin
         n_err++;
         $display("FAIL down_start up=%0b dn=%0b required up=0 dn=1", mov_up, mov_dn);
      end
      wait_until(ready_cyc);
      n_vec++;
      if (sb.size() != 0 || pos !== 3'd0 || match !== 1'b1) begin
         n_err++;
         $display("FAIL down_end pending=%0d pos=%0d match=%0b required 0 0 1", sb.size(), pos, match);
      end
   endtask

   task automatic test_boundary_ignored;
      request(3'd7);
      repeat (5) @(posedge clk);
      #1;
      req_valid  = 1'b1;
      req_target = 3'd2;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_until(ready_cyc);
      repeat (4) @(posedge clk);
      #1;
      n_vec++;
      if (sb.size() != 0 || pos !== 3'd7 || match !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL boundary_end pending=%0d pos=%0d match=%0b busy=%0b required 0 7 1 0",
                  sb.size(), pos, match, busy);
      end
   endtask

   task automatic test_zero_distance;
      request(3'd5);
      wait_until(ready_cyc);
      request(3'd5);
      n_vec++;
      if (busy !== 1'b1 || mov_up !== 1'b0 || mov_dn !== 1'b0 || pos !== 3'd5) begin
         n_err++;
         $display("FAIL zero_start busy=%0b up=%0b dn=%0b pos=%0d required 1 0 0 5",
                  busy, mov_up, mov_dn, pos);
      end
      wait_until(ready_cyc);
      n_vec++;
      if (sb.size() != 0 || pos !== 3'd5 || req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL zero_end pending=%0d pos=%0d ready=%0b required 0 5 1", sb.size(), pos, req_ready);
      end
   endtask

   task automatic test_back_to_back;
      int k_new;
      request(3'd2);
      wait_until(ready_cyc - 3);
      // Held request during DWELL must be taken on the first idle edge.
      req_valid  = 1'b1;
      req_target = 3'd1;
      k_new = ready_cyc + 1;
      wait_until(k_new);
      req_valid = 1'b0;
      push_expect(3'd1, k_new);
      n_vec++;
      if (busy !== 1'b1 || mov_dn !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_start busy=%0b dn=%0b required 1 1", busy, mov_dn);
      end
      wait_until(ready_cyc);
      n_vec++;
      if (sb.size() != 0 || pos !== 3'd1) begin
         n_err++;
         $display("FAIL b2b_end pending=%0d pos=%0d required 0 1", sb.size(), pos);
      end
   endtask

   task automatic test_reset_mid;
      int k;
      request(3'd6);
      k = cyc;
      wait_until(k + 2 * SD + 1);
      n_vec++;
      if (pos !== 3'd3 || mov_up !== 1'b1) begin
         n_err++;
         $display("FAIL mid_before pos=%0d up=%0b required 3 1", pos, mov_up);
      end
      rst_n = 1'b0;
      sb.delete();
      b_start = 1;  b_end = 0;
      mv_start = 1; mv_end = 0;
      @(posedge clk); #1;
      n_vec++;
      if (pos !== 3'd0 || match !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL mid_reset_state pos=%0d match=%0b busy=%0b ready=%0b required 0 1 0 1",
                  pos, match, busy, req_ready);
      end
      n_vec++;
      if (arrived !== 1'b0 || mov_up !== 1'b0 || mov_dn !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_outputs arrived=%0b up=%0b dn=%0b required 0 0 0", arrived, mov_up, mov_dn);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_pos = 3'd0;
      request(3'd2);
      wait_until(ready_cyc);
      n_vec++;
      if (sb.size() != 0 || pos !== 3'd2) begin
         n_err++;
         $display("FAIL mid_recover pending=%0d pos=%0d required 0 2", sb.size(), pos);
      end
   endtask

   initial begin
      test_reset();
      test_up_move();
      test_down_move();
      test_boundary_ignored();
      test_zero_distance();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
